// File: rtl/sram_port_arbiter_if.sv
// Two-master request/grant bus plus the single-port SRAM macro pins.
// master: requesters and the SRAM macro; slave: the arbiter itself.
interface sram_port_arbiter_if #(
   parameter int ADDR_WIDTH_WORDS = 9
);
   logic                        excl_i;
   logic                        m0_req_i,    m1_req_i;
   logic                        m0_we_i,     m1_we_i;
   logic [3:0]                  m0_wmask_i,  m1_wmask_i;
   logic [ADDR_WIDTH_WORDS-1:0] m0_addr_i,   m1_addr_i;
   logic [31:0]                 m0_wdata_i,  m1_wdata_i;
   logic                        m0_gnt_o,    m1_gnt_o;
   logic                        m0_rvalid_o, m1_rvalid_o;
   logic [31:0]                 m0_rdata_o,  m1_rdata_o;
   logic                        sram_clk0_o;
   logic                        sram_csb0_o;
   logic                        sram_web0_o;
   logic [3:0]                  sram_wmask0_o;
   logic [ADDR_WIDTH_WORDS-1:0] sram_addr0_o;
   logic [31:0]                 sram_din0_o;
   logic [31:0]                 sram_dout0_i;

   modport master (
      output excl_i,
      output m0_req_i, m1_req_i, m0_we_i, m1_we_i, m0_wmask_i, m1_wmask_i,
      output m0_addr_i, m1_addr_i, m0_wdata_i, m1_wdata_i,
      input  m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, m0_rdata_o, m1_rdata_o,
      input  sram_clk0_o, sram_csb0_o, sram_web0_o, sram_wmask0_o, sram_addr0_o, sram_din0_o,
      output sram_dout0_i
   );

   modport slave (
      input  excl_i,
      input  m0_req_i, m1_req_i, m0_we_i, m1_we_i, m0_wmask_i, m1_wmask_i,
      input  m0_addr_i, m1_addr_i, m0_wdata_i, m1_wdata_i,
      output m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, m0_rdata_o, m1_rdata_o,
      output sram_clk0_o, sram_csb0_o, sram_web0_o, sram_wmask0_o, sram_addr0_o, sram_din0_o,
      input  sram_dout0_i
   );
endinterface

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter of two masters onto one SRAM port; grant is same-cycle combinational,
// read data returns one cycle after the grant edge, and a new grant may issue every cycle.
module sram_port_arbiter #(
   parameter int ADDR_WIDTH_WORDS = 9
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   sram_port_arbiter_if.slave   bus
);
   logic                        last_q;
   logic                        rd_vld_q;
   logic                        rd_own_q;
   logic                        gnt0;
   logic                        gnt1;
   logic                        any_gnt;
   logic                        sel_we;
   logic [3:0]                  sel_wmask;
   logic [ADDR_WIDTH_WORDS-1:0] sel_addr;
   logic [31:0]                 sel_wdata;

   // Grants are masked by reset so the pins read idle while rstn_i is low.
   always_comb begin
      gnt0 = rstn_i & bus.m0_req_i & (bus.excl_i | ~bus.m1_req_i | last_q);
      gnt1 = rstn_i & bus.m1_req_i & ~bus.excl_i & (~bus.m0_req_i | ~last_q);
   end

   assign any_gnt   = gnt0 | gnt1;
   assign sel_we    = gnt1 ? bus.m1_we_i    : bus.m0_we_i;
   assign sel_wmask = gnt1 ? bus.m1_wmask_i : bus.m0_wmask_i;
   assign sel_addr  = gnt1 ? bus.m1_addr_i  : bus.m0_addr_i;
   assign sel_wdata = gnt1 ? bus.m1_wdata_i : bus.m0_wdata_i;

   assign bus.m0_gnt_o      = gnt0;
   assign bus.m1_gnt_o      = gnt1;
   assign bus.sram_clk0_o   = clk_i;
   assign bus.sram_csb0_o   = ~any_gnt;
   assign bus.sram_web0_o   = ~(any_gnt & sel_we);
   assign bus.sram_wmask0_o = any_gnt ? sel_wmask : 4'h0;
   assign bus.sram_addr0_o  = any_gnt ? sel_addr  : '0;
   assign bus.sram_din0_o   = any_gnt ? sel_wdata : 32'h0;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         last_q   <= 1'b1;
         rd_vld_q <= 1'b0;
         rd_own_q <= 1'b0;
      end else begin
         if (any_gnt) begin
            last_q <= gnt1;
         end
         rd_vld_q <= any_gnt & ~sel_we;
         rd_own_q <= gnt1;
      end
   end

   assign bus.m0_rvalid_o = rd_vld_q & ~rd_own_q;
   assign bus.m1_rvalid_o = rd_vld_q &  rd_own_q;
   assign bus.m0_rdata_o  = bus.m0_rvalid_o ? bus.sram_dout0_i : 32'h0;
   assign bus.m1_rdata_o  = bus.m1_rvalid_o ? bus.sram_dout0_i : 32'h0;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-level arbitration and memory model.
module tb_sram_port_arbiter;
   localparam int AW = 9;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   sram_port_arbiter_if #(.ADDR_WIDTH_WORDS(AW)) bus();

   sram_port_arbiter #(.ADDR_WIDTH_WORDS(AW)) dut (
      .clk_i  (clk),
      .rstn_i (rstn),
      .bus    (bus.slave)
   );

   int vectors     = 0;
   int miscompares = 0;

   logic [31:0] smem [0:511];
   logic [31:0] mmem [0:511];
   int          m_last = 1;
   int          m_pend = -1;
   logic [31:0] m_pend_dat = 32'h0;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] mk);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (mk[b]) r[b*8 +: 8] = nw[b*8 +: 8];
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // SRAM macro: registered read data, byte-masked writes.
   always @(posedge clk) begin
      if (!bus.sram_csb0_o) begin
         if (bus.sram_web0_o)
            bus.sram_dout0_i <= smem[bus.sram_addr0_o];
         else
            smem[bus.sram_addr0_o] = merge(smem[bus.sram_addr0_o], bus.sram_din0_o,
                                           bus.sram_wmask0_o);
      end
   end

   // Reference model: decide the winner from the arbitration rules, check, then commit.
   always @(negedge clk) begin
      int          w;
      logic        e_we;
      logic [AW-1:0] e_addr;
      logic [31:0] e_dat;
      logic [3:0]  e_mk;
      if (!rstn) begin
         m_pend = -1;
         m_last = 1;
         w = -1;
      end else if (bus.excl_i) begin
         w = bus.m0_req_i ? 0 : -1;
      end else if (bus.m0_req_i && bus.m1_req_i) begin
         w = 1 - m_last;
      end else if (bus.m0_req_i) begin
         w = 0;
      end else if (bus.m1_req_i) begin
         w = 1;
      end else begin
         w = -1;
      end
      if (w == 1) begin
         e_we = bus.m1_we_i; e_addr = bus.m1_addr_i; e_dat = bus.m1_wdata_i; e_mk = bus.m1_wmask_i;
      end else begin
         e_we = bus.m0_we_i; e_addr = bus.m0_addr_i; e_dat = bus.m0_wdata_i; e_mk = bus.m0_wmask_i;
      end

      chk("gnt0",   32'(bus.m0_gnt_o),    32'(w == 0));
      chk("gnt1",   32'(bus.m1_gnt_o),    32'(w == 1));
      chk("rvalid0", 32'(bus.m0_rvalid_o), 32'(m_pend == 0));
      chk("rvalid1", 32'(bus.m1_rvalid_o), 32'(m_pend == 1));
      chk("rdata0", bus.m0_rdata_o, (m_pend == 0) ? m_pend_dat : 32'h0);
      chk("rdata1", bus.m1_rdata_o, (m_pend == 1) ? m_pend_dat : 32'h0);
      chk("sram_clk", 32'(bus.sram_clk0_o), 32'(clk));
      chk("csb0",   32'(bus.sram_csb0_o),  32'(w < 0));
      chk("web0",   32'(bus.sram_web0_o),  32'((w < 0) || !e_we));
      chk("wmask0", 32'(bus.sram_wmask0_o), (w < 0) ? 32'h0 : 32'(e_mk));
      chk("addr0",  32'(bus.sram_addr0_o),  (w < 0) ? 32'h0 : 32'(e_addr));
      chk("din0",   bus.sram_din0_o,        (w < 0) ? 32'h0 : e_dat);

      m_pend = -1;
      if (w >= 0) begin
         m_last = w;
         if (e_we) begin
            mmem[e_addr] = merge(mmem[e_addr], e_dat, e_mk);
         end else begin
            m_pend_dat = mmem[e_addr];
            m_pend     = w;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic look();
      @(negedge clk);
      #1;
   endtask

   task automatic mset(input int m, input logic req, input logic we, input logic [AW-1:0] addr,
                       input logic [31:0] dat, input logic [3:0] mk);
      if (m == 0) begin
         bus.m0_req_i = req; bus.m0_we_i = we; bus.m0_addr_i = addr;
         bus.m0_wdata_i = dat; bus.m0_wmask_i = mk;
      end else begin
         bus.m1_req_i = req; bus.m1_we_i = we; bus.m1_addr_i = addr;
         bus.m1_wdata_i = dat; bus.m1_wmask_i = mk;
      end
   endtask

   task automatic idle();
      mset(0, 1'b0, 1'b0, '0, 32'h0, 4'h0);
      mset(1, 1'b0, 1'b0, '0, 32'h0, 4'h0);
   endtask

   initial begin
      for (int i = 0; i < 512; i++) begin
         smem[i] = 32'h0;
         mmem[i] = 32'h0;
      end
      bus.excl_i = 1'b0;
      idle();

      // Reset values.
      look();
      chk("rst_csb0",   32'(bus.sram_csb0_o), 32'd1);
      chk("rst_web0",   32'(bus.sram_web0_o), 32'd1);
      chk("rst_rvalid0", 32'(bus.m0_rvalid_o), 32'd0);
      step();
      rstn = 1'b1;

      // Both masters request continuously: strict alternation starting with m0.
      mset(0, 1'b1, 1'b0, 9'd0, 32'h0, 4'h0);
      mset(1, 1'b1, 1'b0, 9'd0, 32'h0, 4'h0);
      for (int i = 0; i < 6; i++) begin
         look();
         chk("alt_gnt0", 32'(bus.m0_gnt_o), 32'(i % 2 == 0));
         chk("alt_gnt1", 32'(bus.m1_gnt_o), 32'(i % 2 == 1));
         step();
      end
      idle();
      step();

      // Full-word write then read back on m0.
      mset(0, 1'b1, 1'b1, 9'd5, 32'hDEADBEEF, 4'hF);
      look();
      chk("wr5_gnt0", 32'(bus.m0_gnt_o), 32'd1);
      step();
      mset(0, 1'b1, 1'b0, 9'd5, 32'h0, 4'h0);
      look();
      chk("rd5_web0", 32'(bus.sram_web0_o), 32'd1);
      step();
      idle();
      look();
      chk("rd5_rvalid0", 32'(bus.m0_rvalid_o), 32'd1);
      chk("rd5_rdata0",  bus.m0_rdata_o, 32'hDEADBEEF);
      step();

      // Single-byte write over zero content.
      mset(0, 1'b1, 1'b1, 9'd7, 32'h11223344, 4'h4);
      step();
      mset(0, 1'b1, 1'b0, 9'd7, 32'h0, 4'h0);
      step();
      idle();
      look();
      chk("rd7_rdata0", bus.m0_rdata_o, 32'h00220000);
      step();

      // Exclusive mode locks out m1; m1 wins immediately once released.
      bus.excl_i = 1'b1;
      mset(0, 1'b1, 1'b0, 9'd1, 32'h0, 4'h0);
      mset(1, 1'b1, 1'b0, 9'd2, 32'h0, 4'h0);
      for (int i = 0; i < 4; i++) begin
         look();
         chk("excl_gnt0", 32'(bus.m0_gnt_o), 32'd1);
         chk("excl_gnt1", 32'(bus.m1_gnt_o), 32'd0);
         step();
      end
      bus.excl_i = 1'b0;
      look();
      chk("unexcl_gnt1", 32'(bus.m1_gnt_o), 32'd1);
      step();
      idle();
      step();

      // Reset pulse discards m1's pending read.
      mset(1, 1'b1, 1'b0, 9'd5, 32'h0, 4'h0);
      look();
      chk("rstpulse_gnt1", 32'(bus.m1_gnt_o), 32'd1);
      step();
      idle();
      rstn = 1'b0;
      look();
      chk("rstpulse_rvalid1", 32'(bus.m1_rvalid_o), 32'd0);
      chk("rstpulse_csb0",    32'(bus.sram_csb0_o), 32'd1);
      step();
      rstn = 1'b1;
      look();
      chk("after_rst_rvalid1", 32'(bus.m1_rvalid_o), 32'd0);
      step();

      // Random traffic with occasional exclusive cycles and reset pulses.
      for (int i = 0; i < 3000; i++) begin
         rstn       = ($urandom_range(0, 99) != 0);
         bus.excl_i = ($urandom_range(0, 7) == 0);
         for (int m = 0; m < 2; m++)
            mset(m, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 AW'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
         step();
      end
      rstn = 1'b1;
      bus.excl_i = 1'b0;
      idle();
      step();
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH_WORDS, default 9, word-address width of the 32x512 SRAM port.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state SHALL be clocked on its rising edge.
REQ-003 SHALL have port rstn_i, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port excl_i, input, 1, exclusive mode; when 1, only m0 may be granted.
REQ-005 SHALL have ports m0_req_i, m1_req_i, input, 1 each, access requests.
REQ-006 SHALL have ports m0_we_i, m1_we_i, input, 1 each; 1 means write, 0 means read.
REQ-007 SHALL have ports m0_wmask_i, m1_wmask_i, input, 4 each, byte write enables.
REQ-008 SHALL have ports m0_addr_i, m1_addr_i, input, ADDR_WIDTH_WORDS each, word addresses.
REQ-009 SHALL have ports m0_wdata_i, m1_wdata_i, input, 32 each, write data.
REQ-010 SHALL have ports m0_gnt_o, m1_gnt_o, output, 1 each, request accepted this cycle.
REQ-011 SHALL have ports m0_rvalid_o, m1_rvalid_o, output, 1 each, read data valid.
REQ-012 SHALL have ports m0_rdata_o, m1_rdata_o, output, 32 each, read data.
REQ-013 SHALL have port sram_clk0_o, output, 1, equal to clk_i.
REQ-014 SHALL have port sram_csb0_o, output, 1, active-low chip select.
REQ-015 SHALL have port sram_web0_o, output, 1, active-low write enable.
REQ-016 SHALL have port sram_wmask0_o, output, 4, byte mask.
REQ-017 SHALL have port sram_addr0_o, output, ADDR_WIDTH_WORDS, word address.
REQ-018 SHALL have port sram_din0_o, output, 32, write data.
REQ-019 SHALL have port sram_dout0_i, input, 32, SRAM read data, valid one cycle after the access edge.

Function
REQ-020 Grant SHALL be combinational from the requests and the registered state; a transfer completes at the rising edge where req and gnt are both 1.
REQ-021 At most one of m0_gnt_o and m1_gnt_o SHALL be 1 in any cycle.
REQ-022 A single requester (excl_i=0) SHALL be granted in the same cycle.
REQ-023 When both request with excl_i=0, the grant SHALL go to the master not granted most recently; a register last_q (0=m0, 1=m1) SHALL update at every completed transfer.
REQ-024 When excl_i=1, m1_gnt_o SHALL be 0 and m0 SHALL be granted whenever m0_req_i=1; last_q SHALL still update.
REQ-025 When a grant is active, the SRAM pins SHALL carry the granted master's addr, wdata and wmask, with csb0=0 and web0=~we, in the same cycle.
REQ-026 When there is no grant, the pins SHALL be csb0=1, web0=1, wmask0=0, addr0=0, din0=0.
REQ-027 A granted read at edge N SHALL assert that master's rvalid for exactly the cycle following N; in that cycle its rdata SHALL equal sram_dout0_i.
REQ-028 rdata_o SHALL be 0 whenever the corresponding rvalid_o is 0.
REQ-029 A granted write SHALL produce no rvalid.
REQ-030 A new grant SHALL be allowed every cycle, including the cycle in which a previous read's rvalid is high; the pending-read owner register SHALL be a one-deep pipeline stage.
REQ-031 With excl_i=0 and a continuously asserted request, a master SHALL be granted within 2 cycles; there SHALL be no starvation.
REQ-032 A toggle of excl_i SHALL affect only the grant of the current cycle; pending rvalid SHALL still be delivered.

Reset
REQ-033 While rstn_i=0, outputs SHALL be: gnt=0, rvalid=0, rdata=0, csb0=1, web0=1, wmask0=0, addr0=0, din0=0.
REQ-034 Reset SHALL set last_q=1 so that m0 wins the first conflict, and SHALL clear the pending-read register.
REQ-035 Reset asserted mid-operation SHALL discard any pending read; no rvalid SHALL appear after deassertion until a new grant.

Verification
REQ-036 Write then read on m0: write addr 5, data 0xDEADBEEF, mask 0xF; then read addr 5 -> m0_rvalid_o is 1 one cycle after the read grant, and m0_rdata_o=0xDEADBEEF.
REQ-037 Both masters request continuously for 6 cycles after reset -> grants alternate m0, m1, m0, m1, m0, m1.
REQ-038 excl_i=1 with both requesting for 4 cycles -> m0 is granted every cycle and m1_gnt_o stays 0; after excl_i returns to 0, m1 is granted next.
REQ-039 Byte write: write 0x11223344 to addr 7 with mask 0x4, over prior content 0 -> a read of addr 7 returns 0x00220000.
REQ-040 m1 read granted, then rstn_i pulsed low before the rvalid cycle -> m1_rvalid_o stays 0, and all pins hold their reset values.
